// File: rtl/vga_timing_ctrl_pkg.sv
// Shared types and constants for the raster timing block: phase encoding, the
// shadowed timing configuration, and the CTRL.DIV field position used by the register block.
package vga_timing_ctrl_pkg;

  localparam int unsigned CtrlDivLsb = 3;
  localparam int unsigned CtrlDivMsb = 10;
  localparam int unsigned DivW       = CtrlDivMsb - CtrlDivLsb + 1;
  localparam int unsigned CntW       = 16;

  typedef enum logic [1:0] {
    PhVis,
    PhFp,
    PhSync,
    PhBp
  } vga_phase_e;

  typedef struct packed {
    logic [CntW-1:0] hvsize;
    logic [CntW-1:0] hfpsize;
    logic [CntW-1:0] hsyncsize;
    logic [CntW-1:0] hbpsize;
    logic [CntW-1:0] vvsize;
    logic [CntW-1:0] vfpsize;
    logic [CntW-1:0] vsyncsize;
    logic [CntW-1:0] vbpsize;
    logic            hspol;
    logic            vspol;
  } timing_cfg_t;

  function automatic vga_phase_e next_phase(input vga_phase_e ph);
    case (ph)
      PhVis:   return PhFp;
      PhFp:    return PhSync;
      PhSync:  return PhBp;
      default: return PhVis;
    endcase
  endfunction

  // RGB565 colour bars, left to right.
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h8410;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Timing outputs from the raster sequencer to the pad, pixel/FIFO and DMA/IRQ logic.
// The master side (vga_timing_ctrl) drives every signal.
interface vga_timing_ctrl_if #(
  parameter int unsigned CNT_W = vga_timing_ctrl_pkg::CntW
);
  logic             pix_tick;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] hpos;
  logic [CNT_W-1:0] vpos;
  logic             line_req;
  logic             frame_end;
  logic [15:0]      test_rgb;

  modport master (
    output pix_tick, hsync, vsync, de, hpos, vpos, line_req, frame_end, test_rgb
  );

  modport slave (
    input pix_tick, hsync, vsync, de, hpos, vpos, line_req, frame_end, test_rgb
  );
endinterface

// File: rtl/vga_timing_ctrl_porch_fsm.sv
// One VIS->FP->SYNC->BP phase sequencer with its in-phase counter.
// Used for both axes: horizontal advances on pixel ticks, vertical on line ends.
module vga_timing_ctrl_porch_fsm
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CntW
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [CNT_W-1:0] vis_size_i,
  input  logic [CNT_W-1:0] fp_size_i,
  input  logic [CNT_W-1:0] sync_size_i,
  input  logic [CNT_W-1:0] bp_size_i,
  output vga_phase_e       phase_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o,
  output logic             wrap_o
);

  vga_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] size;
  logic [CNT_W-1:0] last_val;

  always_comb begin
    case (phase_q)
      PhVis:   size = vis_size_i;
      PhFp:    size = fp_size_i;
      PhSync:  size = sync_size_i;
      default: size = bp_size_i;
    endcase
  end

  // A zero size still occupies one advance, so the counter never wraps.
  assign last_val = (size == '0) ? '0 : size - 1'b1;
  assign last_o   = (cnt_q == last_val);
  assign wrap_o   = adv_i && last_o && (phase_q == PhBp);
  assign phase_o  = phase_q;
  assign cnt_o    = cnt_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      phase_d = PhVis;
      cnt_d   = '0;
    end else if (adv_i) begin
      if (last_o) begin
        phase_d = next_phase(phase_q);
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q <= PhVis;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing sequencer: pixel-tick divider, H/V porch FSMs, shadowed config, registered
// sync/DE/position/strobe outputs. Define VGA_TIMING_TEST_EN to enable the colour-bar pattern.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CntW,
  parameter int unsigned DIV_W = DivW
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              hspol_i,
  input  logic              vspol_i,
  input  logic              test_i,
  input  logic [CNT_W-1:0]  hvsize_i,
  input  logic [CNT_W-1:0]  hfpsize_i,
  input  logic [CNT_W-1:0]  hsyncsize_i,
  input  logic [CNT_W-1:0]  hbpsize_i,
  input  logic [CNT_W-1:0]  vvsize_i,
  input  logic [CNT_W-1:0]  vfpsize_i,
  input  logic [CNT_W-1:0]  vsyncsize_i,
  input  logic [CNT_W-1:0]  vbpsize_i,
  vga_timing_ctrl_if.master vga
);

  timing_cfg_t      live_cfg, cfg, shadow_q, shadow_d;
  logic             en_q;
  logic [DIV_W-1:0] dcnt_q, dcnt_d, div_q, div_d, div_cur;
  logic             tick, clr;

  vga_phase_e       h_phase, v_phase;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, v_last, line_end, frame_end, line_req, next_line_vis;

  logic             pix_tick_q, pix_tick_d, hact_q, hact_d, vact_q, vact_d;
  logic             hpol_q, hpol_d, vpol_q, vpol_d, de_q, de_d;
  logic [CNT_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic             line_req_q, line_req_d, frame_end_q, frame_end_d;

  assign live_cfg = '{hvsize: hvsize_i, hfpsize: hfpsize_i, hsyncsize: hsyncsize_i,
                      hbpsize: hbpsize_i, vvsize: vvsize_i, vfpsize: vfpsize_i,
                      vsyncsize: vsyncsize_i, vbpsize: vbpsize_i,
                      hspol: hspol_i, vspol: vspol_i};

  // The first enabled cycle runs straight off the inputs while the shadows capture them.
  assign cfg     = en_q ? shadow_q : live_cfg;
  assign div_cur = en_q ? div_q : div_i;
  assign clr     = ~en_i;
  assign tick    = en_i && (dcnt_q == div_cur);
  assign dcnt_d  = (!en_i || tick) ? '0 : dcnt_q + 1'b1;
  assign div_d   = (!en_q || tick) ? div_i : div_q;

  vga_timing_ctrl_porch_fsm #(.CNT_W(CNT_W)) u_hfsm (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (clr),
    .adv_i      (tick),
    .vis_size_i (cfg.hvsize),
    .fp_size_i  (cfg.hfpsize),
    .sync_size_i(cfg.hsyncsize),
    .bp_size_i  (cfg.hbpsize),
    .phase_o    (h_phase),
    .cnt_o      (h_cnt),
    .last_o     (h_last),
    .wrap_o     (line_end)
  );

  vga_timing_ctrl_porch_fsm #(.CNT_W(CNT_W)) u_vfsm (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (clr),
    .adv_i      (line_end),
    .vis_size_i (cfg.vvsize),
    .fp_size_i  (cfg.vfpsize),
    .sync_size_i(cfg.vsyncsize),
    .bp_size_i  (cfg.vbpsize),
    .phase_o    (v_phase),
    .cnt_o      (v_cnt),
    .last_o     (v_last),
    .wrap_o     (frame_end)
  );

  // Line after the current one is visible: more VIS lines remain, or the frame wraps.
  assign next_line_vis = ((v_phase == PhVis) && !v_last) || ((v_phase == PhBp) && v_last);
  assign line_req      = tick && (h_phase == PhSync) && h_last && next_line_vis;
  assign shadow_d      = (!en_q || frame_end) ? live_cfg : shadow_q;

  always_comb begin
    pix_tick_d  = 1'b0;
    hact_d      = 1'b0;
    vact_d      = 1'b0;
    hpol_d      = cfg.hspol;
    vpol_d      = cfg.vspol;
    de_d        = 1'b0;
    hpos_d      = '0;
    vpos_d      = '0;
    line_req_d  = 1'b0;
    frame_end_d = 1'b0;
    if (en_i) begin
      pix_tick_d  = tick;
      hact_d      = (h_phase == PhSync);
      vact_d      = (v_phase == PhSync);
      de_d        = (h_phase == PhVis) && (v_phase == PhVis);
      hpos_d      = (h_phase == PhVis) ? h_cnt : '0;
      vpos_d      = (v_phase == PhVis) ? v_cnt : '0;
      line_req_d  = line_req;
      frame_end_d = frame_end;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q        <= 1'b0;
      dcnt_q      <= '0;
      div_q       <= '0;
      shadow_q    <= '0;
      pix_tick_q  <= 1'b0;
      hact_q      <= 1'b0;
      vact_q      <= 1'b0;
      hpol_q      <= 1'b0;
      vpol_q      <= 1'b0;
      de_q        <= 1'b0;
      hpos_q      <= '0;
      vpos_q      <= '0;
      line_req_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      en_q        <= en_i;
      dcnt_q      <= dcnt_d;
      div_q       <= div_d;
      shadow_q    <= shadow_d;
      pix_tick_q  <= pix_tick_d;
      hact_q      <= hact_d;
      vact_q      <= vact_d;
      hpol_q      <= hpol_d;
      vpol_q      <= vpol_d;
      de_q        <= de_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      line_req_q  <= line_req_d;
      frame_end_q <= frame_end_d;
    end
  end

  // While idle the sync pins follow the live polarity so the pads never glitch active.
  assign vga.hsync     = en_q ? (hact_q ~^ hpol_q) : ~hspol_i;
  assign vga.vsync     = en_q ? (vact_q ~^ vpol_q) : ~vspol_i;
  assign vga.pix_tick  = pix_tick_q;
  assign vga.de        = de_q;
  assign vga.hpos      = hpos_q;
  assign vga.vpos      = vpos_q;
  assign vga.line_req  = line_req_q;
  assign vga.frame_end = frame_end_q;

`ifdef VGA_TIMING_TEST_EN
  logic [2:0]       bar_q, bar_d;
  logic [CNT_W-1:0] bar_pix_q, bar_pix_d, bar_w, bar_last;
  logic [15:0]      rgb_q, rgb_d;

  assign bar_w    = cfg.hvsize >> 3;
  assign bar_last = (bar_w == '0) ? '0 : bar_w - 1'b1;

  always_comb begin
    bar_d     = bar_q;
    bar_pix_d = bar_pix_q;
    if (!en_i || (h_phase != PhVis)) begin
      bar_d     = '0;
      bar_pix_d = '0;
    end else if (tick) begin
      if (bar_pix_q == bar_last) begin
        bar_pix_d = '0;
        if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + 1'b1;
      end
    end
  end

  assign rgb_d = (en_i && test_i && de_d) ? bar_colour(bar_q) : 16'h0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bar_q     <= '0;
      bar_pix_q <= '0;
      rgb_q     <= '0;
    end else begin
      bar_q     <= bar_d;
      bar_pix_q <= bar_pix_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vga.test_rgb = rgb_q;
`else
  logic unused_test;
  assign unused_test  = test_i;
  assign vga.test_rgb = 16'h0;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: reset, divider, porch timing, shadowing, polarity,
// enable abort/restart, zero sizes and (with VGA_TIMING_TEST_EN) the colour-bar pattern.
module tb_vga_timing_ctrl;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [7:0]       div;
  logic             hspol, vspol, test;
  logic [CNT_W-1:0] hv, hf, hs, hb, vv, vf, vs, vb;

  int checks = 0;
  int errors = 0;
  int kn     = 0;

  vga_timing_ctrl_if #(.CNT_W(CNT_W)) vga ();

  vga_timing_ctrl #(.CNT_W(CNT_W), .DIV_W(8)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .div_i      (div),
    .hspol_i    (hspol),
    .vspol_i    (vspol),
    .test_i     (test),
    .hvsize_i   (hv),
    .hfpsize_i  (hf),
    .hsyncsize_i(hs),
    .hbpsize_i  (hb),
    .vvsize_i   (vv),
    .vfpsize_i  (vf),
    .vsyncsize_i(vs),
    .vbpsize_i  (vb),
    .vga        (vga)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enable at a falling edge; output cycle k is sampled k falling edges later.
  task automatic start();
    en = 1'b1;
    kn = 0;
  endtask

  task automatic at_k(input int k);
    cyc(k - kn);
    kn = k;
  endtask

  task automatic sizes(input int a, input int b, input int c, input int d,
                       input int e, input int f, input int g, input int h);
    hv = CNT_W'(a); hf = CNT_W'(b); hs = CNT_W'(c); hb = CNT_W'(d);
    vv = CNT_W'(e); vf = CNT_W'(f); vs = CNT_W'(g); vb = CNT_W'(h);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h8410};

    rst_n = 1'b0; en = 1'b0; div = 8'd0; hspol = 1'b1; vspol = 1'b1; test = 1'b0;
    sizes(4, 1, 2, 1, 3, 1, 1, 1);
    cyc(2);
    check("rst_hsync", vga.hsync, 0);
    check("rst_vsync", vga.vsync, 0);
    check("rst_de", vga.de, 0);
    check("rst_tick", vga.pix_tick, 0);
    check("rst_fend", vga.frame_end, 0);
    rst_n = 1'b1;
    cyc(2);
    check("idle_hsync", vga.hsync, 0);
    check("idle_de", vga.de, 0);

    // 1: div=0, H 4/1/2/1 (8 clks), V 3/1/1/1 (48 clks)
    start();
    at_k(1);  check("t1_tick", vga.pix_tick, 1); check("t1_de0", vga.de, 1);
              check("t1_hpos0", vga.hpos, 0); check("t1_hs0", vga.hsync, 0);
    at_k(4);  check("t1_de3", vga.de, 1); check("t1_hpos3", vga.hpos, 3);
    at_k(5);  check("t1_hfp_de", vga.de, 0); check("t1_hfp_hpos", vga.hpos, 0);
    at_k(6);  check("t1_hs_on", vga.hsync, 1);
    at_k(7);  check("t1_hs_on2", vga.hsync, 1); check("t1_lreq", vga.line_req, 1);
    at_k(8);  check("t1_hs_off", vga.hsync, 0); check("t1_lreq_off", vga.line_req, 0);
    at_k(9);  check("t1_l1_de", vga.de, 1); check("t1_vpos1", vga.vpos, 1);
    at_k(33); check("t1_vs_on", vga.vsync, 1);
    at_k(41); check("t1_vs_off", vga.vsync, 0);
    at_k(47); check("t1_lreq_vbp", vga.line_req, 1); check("t1_vbp_de", vga.de, 0);
    at_k(48); check("t1_fend", vga.frame_end, 1);
    at_k(49); check("t1_fend_off", vga.frame_end, 0); check("t1_f2_de", vga.de, 1);
              check("t1_f2_vpos", vga.vpos, 0); check("t1_rgb0", vga.test_rgb, 0);
    at_k(95); check("t1_fend_95", vga.frame_end, 0);
    at_k(96); check("t1_fend_96", vga.frame_end, 1);

    // 2: div=3 -> tick every 4 clks, line 32, frame 192
    en = 1'b0;
    cyc(1);
    check("t2_idle_de", vga.de, 0); check("t2_idle_hs", vga.hsync, 0);
    div = 8'd3;
    start();
    at_k(1);   check("t2_tick1", vga.pix_tick, 0); check("t2_de", vga.de, 1);
    at_k(4);   check("t2_tick4", vga.pix_tick, 1);
    at_k(5);   check("t2_tick5", vga.pix_tick, 0); check("t2_hpos1", vga.hpos, 1);
    at_k(8);   check("t2_tick8", vga.pix_tick, 1);
    at_k(16);  check("t2_de16", vga.de, 1); check("t2_hpos3", vga.hpos, 3);
    at_k(17);  check("t2_de17", vga.de, 0);
    at_k(20);  check("t2_hs20", vga.hsync, 0);
    at_k(21);  check("t2_hs21", vga.hsync, 1);
    at_k(28);  check("t2_hs28", vga.hsync, 1);
    at_k(29);  check("t2_hs29", vga.hsync, 0);
    at_k(191); check("t2_fend191", vga.frame_end, 0);
    at_k(192); check("t2_fend192", vga.frame_end, 1);
    at_k(193); check("t2_fend193", vga.frame_end, 0);

    // 3: hvsize 4->6 mid-frame only takes effect next frame
    en = 1'b0;
    cyc(1);
    div = 8'd0;
    start();
    at_k(10);  hv = 16'd6;
    at_k(20);  check("t3_old_de", vga.de, 1); check("t3_old_hpos", vga.hpos, 3);
    at_k(21);  check("t3_old_end", vga.de, 0);
    at_k(48);  check("t3_fend1", vga.frame_end, 1);
    at_k(54);  check("t3_new_de", vga.de, 1); check("t3_new_hpos", vga.hpos, 5);
    at_k(55);  check("t3_new_end", vga.de, 0);
    at_k(107); check("t3_fend107", vga.frame_end, 0);
    at_k(108); check("t3_fend108", vga.frame_end, 1);
    hv = 16'd4;

    // 4: inverted polarity, then abort mid-line and restart at (0,0)
    en = 1'b0; hspol = 1'b0; vspol = 1'b0;
    cyc(1);
    check("t4_idle_hs", vga.hsync, 1); check("t4_idle_vs", vga.vsync, 1);
    start();
    at_k(1);  check("t4_hs1", vga.hsync, 1); check("t4_de1", vga.de, 1);
    at_k(6);  check("t4_hs6", vga.hsync, 0);
    at_k(8);  check("t4_hs8", vga.hsync, 1);
    at_k(33); check("t4_vs33", vga.vsync, 0);
    at_k(41); check("t4_vs41", vga.vsync, 1);
    at_k(50); check("t4_pre_de", vga.de, 1); check("t4_pre_hpos", vga.hpos, 1);
    en = 1'b0;
    cyc(1);
    check("t4_ab_de", vga.de, 0); check("t4_ab_hpos", vga.hpos, 0);
    check("t4_ab_hs", vga.hsync, 1); check("t4_ab_vs", vga.vsync, 1);
    check("t4_ab_tick", vga.pix_tick, 0);
    start();
    at_k(1);  check("t4_rs_de", vga.de, 1); check("t4_rs_hpos", vga.hpos, 0);
              check("t4_rs_vpos", vga.vpos, 0); check("t4_rs_tick", vga.pix_tick, 1);
    at_k(2);  check("t4_rs_hpos1", vga.hpos, 1);
    en = 1'b0; hspol = 1'b1; vspol = 1'b1;

    // 5: all sizes zero -> every phase one tick, line 4 clks, frame 16 clks
    sizes(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1);
    start();
    at_k(1);  check("t5_de1", vga.de, 1);
    at_k(2);  check("t5_de2", vga.de, 0);
    at_k(3);  check("t5_hs3", vga.hsync, 1);
    at_k(4);  check("t5_hs4", vga.hsync, 0);
    at_k(5);  check("t5_vfp_de", vga.de, 0);
    at_k(9);  check("t5_vs9", vga.vsync, 1);
    at_k(13); check("t5_vs13", vga.vsync, 0);
    at_k(15); check("t5_lreq", vga.line_req, 1);
    at_k(16); check("t5_fend16", vga.frame_end, 1);
    at_k(17); check("t5_de17", vga.de, 1);
    at_k(32); check("t5_fend32", vga.frame_end, 1);

`ifdef VGA_TIMING_TEST_EN
    // 6: eight one-pixel colour bars with hvsize=8
    en = 1'b0;
    sizes(8, 1, 1, 1, 1, 1, 1, 1);
    test = 1'b1;
    cyc(1);
    start();
    for (int i = 1; i <= 8; i++) begin
      at_k(i);
      check("t6_bar", vga.test_rgb, bars[i-1]);
    end
    at_k(9); check("t6_blank", vga.test_rgb, 0);
    test = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
